// File: rtl/systolic_feeder.sv
// systolic_feeder: holds operand matrices A and B. On start it loads the B rows
// onto the array's north bus, last row first. It then streams A onto the west
// bus as a skewed wavefront, waits a fixed drain window and pulses done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting; row writes accepted; start launches a pass
// ST_LOAD   | t = 0..N-1, north carries B[N-1-t]
// ST_STREAM | t = N..3N-2, west lane i carries A[t-N-i][i] when in range
// ST_DRAIN  | t = 3N-1..3N-2+DRAIN_CYCLES, all data outputs zero
// ST_DONE   | one-cycle done pulse; start here chains the next pass
module systolic_feeder #(
    parameter int N            = 4,
    parameter int NUM_BITS     = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en_i,
    input  logic                             wr_sel_i,
    input  logic [$clog2(N)-1:0]             wr_row_i,
    input  logic [N-1:0][NUM_BITS-1:0]       wr_data_i,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             load_o,
    output logic [N-1:0][NUM_BITS-1:0]       north_o,
    output logic [N-1:0][NUM_BITS-1:0]       west_o
);

    localparam int RW = $clog2(N);
    localparam int TW = $clog2(3*N + DRAIN_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [TW-1:0]                         r_t;
    logic [TW-1:0]                         w_t_nxt;
    logic [N-1:0][N-1:0][NUM_BITS-1:0]     r_a;
    logic [N-1:0][N-1:0][NUM_BITS-1:0]     r_b;
    logic [N-1:0][N-1:0][NUM_BITS-1:0]     w_b_nxt;
    logic                                  w_wr_ok;
    logic [RW-1:0]                         w_load_row;
    logic [N-1:0][NUM_BITS-1:0]            w_north_nxt;
    logic [N-1:0][NUM_BITS-1:0]            w_west_nxt;
    logic                                  r_busy;
    logic                                  r_done;
    logic                                  r_load;
    logic [N-1:0][NUM_BITS-1:0]            r_north;
    logic [N-1:0][NUM_BITS-1:0]            r_west;

    // Buffers are only writable while idle, so they stay frozen during a pass.
    assign w_wr_ok = wr_en_i && (r_state == ST_IDLE);

    // Operand buffers: one row committed per accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_wr_ok) begin
            if (wr_sel_i) r_b[wr_row_i] <= wr_data_i;
            else          r_a[wr_row_i] <= wr_data_i;
        end
    end

    // B as it will be after this edge, so a write alongside start feeds t=0.
    always_comb begin
        w_b_nxt = r_b;
        if (w_wr_ok && wr_sel_i) w_b_nxt[wr_row_i] = wr_data_i;
    end

    // Phase sequencing and the running cycle index t.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t + 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_t_nxt = '0;
                if (start_i) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (r_t == TW'(N - 1)) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_t == TW'(3*N - 2)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_t == TW'(3*N - 2 + DRAIN_CYCLES)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_t_nxt     = '0;
                w_state_nxt = start_i ? ST_LOAD : ST_IDLE;
            end
            default: begin
                w_t_nxt     = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Last B row goes out first: row index is N-1-t during LOAD.
    assign w_load_row  = RW'(N - 1) - RW'(w_t_nxt);
    assign w_north_nxt = (w_state_nxt == ST_LOAD) ? w_b_nxt[w_load_row] : '0;

    // Lane i lags lane i-1 by one cycle; it carries column i of A, row by row.
    for (genvar gi = 0; gi < N; gi++) begin : g_west
        logic [RW-1:0] w_k;
        logic          w_lane_on;
        assign w_k       = RW'(w_t_nxt - TW'(N + gi));
        assign w_lane_on = (w_state_nxt == ST_STREAM) &&
                           (w_t_nxt >= TW'(N + gi)) && (w_t_nxt < TW'(2*N + gi));
        assign w_west_nxt[gi] = w_lane_on ? r_a[w_k][gi] : '0;
    end

    // FSM state, phase counter and registered outputs derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= 1'b0;
            r_north <= '0;
            r_west  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_STREAM) ||
                       (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_DONE);
            r_load  <= (w_state_nxt == ST_LOAD);
            r_north <= w_north_nxt;
            r_west  <= w_west_nxt;
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign load_o  = r_load;
    assign north_o = r_north;
    assign west_o  = r_west;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed phases with random matrix contents,
// compared cycle by cycle against a matrix-level reference model.
module tb_systolic_feeder;

    localparam int N      = 4;
    localparam int NB     = 8;
    localparam int D      = 8;
    localparam int RW     = $clog2(N);
    localparam int T_DONE = 3*N - 1 + D;

    typedef logic [N-1:0][NB-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_i;
    logic          wr_sel_i;
    logic [RW-1:0] wr_row_i;
    row_t          wr_data_i;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          load_o;
    row_t          north_o;
    row_t          west_o;

    int total = 0;
    int bad   = 0;
    int ma[N][N];
    int mb[N][N];

    systolic_feeder #(.N(N), .NUM_BITS(NB), .DRAIN_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_i),
        .wr_sel_i  (wr_sel_i),
        .wr_row_i  (wr_row_i),
        .wr_data_i (wr_data_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .load_o    (load_o),
        .north_o   (north_o),
        .west_o    (west_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t row_a(input int r);
        row_t v;
        for (int j = 0; j < N; j++) v[j] = NB'(ma[r][j]);
        return v;
    endfunction

    function automatic row_t row_b(input int r);
        row_t v;
        for (int j = 0; j < N; j++) v[j] = NB'(mb[r][j]);
        return v;
    endfunction

    // Idle-time row write; the model commits it as well.
    task automatic wr(input bit sel, input int row, input row_t d);
        wr_en_i   = 1'b1;
        wr_sel_i  = sel;
        wr_row_i  = RW'(row);
        wr_data_i = d;
        for (int j = 0; j < N; j++) begin
            if (sel) mb[row][j] = int'(d[j]);
            else     ma[row][j] = int'(d[j]);
        end
        @(posedge clk); #1;
        wr_en_i = 1'b0;
    endtask

    task automatic write_model_rows();
        for (int r = 0; r < N; r++) wr(1'b0, r, row_a(r));
        for (int r = 0; r < N; r++) wr(1'b1, r, row_b(r));
    endtask

    task automatic start_pass();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Expected outputs at pass cycle t from the matrix-level description.
    task automatic expect_at(input int t, output row_t en, output row_t ew);
        en = '0;
        ew = '0;
        if (t < N) en = row_b(N - 1 - t);
        if (t >= N && t <= 3*N - 2) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (t - N) - i;
                if (k >= 0 && k < N) ew[i] = NB'(ma[k][i]);
            end
        end
    endtask

    // Called when the DUT is in cycle t=0; walks the whole pass.
    task automatic run_pass(input string name, input bit chain, input bit noise);
        row_t en, ew;
        for (int t = 0; t <= T_DONE; t++) begin
            expect_at(t, en, ew);
            chk($sformatf("%s busy t=%0d", name, t), 64'(busy_o), 64'(t < T_DONE));
            chk($sformatf("%s done t=%0d", name, t), 64'(done_o), 64'(t == T_DONE));
            chk($sformatf("%s load t=%0d", name, t), 64'(load_o), 64'(t < N));
            chk($sformatf("%s north t=%0d", name, t), 64'(north_o), 64'(en));
            chk($sformatf("%s west t=%0d", name, t), 64'(west_o), 64'(ew));
            if (noise) begin
                if (t == 1 || t == 13) start_i = 1'b1;
                if (t == 5) begin
                    wr_en_i   = 1'b1;
                    wr_sel_i  = 1'b0;
                    wr_row_i  = '0;
                    wr_data_i = {N{NB'(99)}};
                end
            end
            if (chain && t == T_DONE) start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            wr_en_i = 1'b0;
        end
        if (!chain) begin
            chk({name, " idle busy"}, 64'(busy_o), 64'(0));
            chk({name, " idle done"}, 64'(done_o), 64'(0));
            chk({name, " idle north"}, 64'(north_o), 64'(0));
            chk({name, " idle west"}, 64'(west_o), 64'(0));
        end
    endtask

    initial begin
        bit done_seen;
        rst       = 1'b1;
        wr_en_i   = 1'b0;
        wr_sel_i  = 1'b0;
        wr_row_i  = '0;
        wr_data_i = '0;
        start_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset done", 64'(done_o), 64'(0));
        chk("reset load", 64'(load_o), 64'(0));
        chk("reset north", 64'(north_o), 64'(0));
        chk("reset west", 64'(west_o), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity matrices.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = (r == c) ? 1 : 0;
            end
        write_model_rows();
        start_pass();
        run_pass("ident", 1'b0, 1'b0);

        // Ordering pattern.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 4*r + c + 1;
                mb[r][c] = 16 + 4*r + c;
            end
        write_model_rows();
        start_pass();
        run_pass("order", 1'b0, 1'b0);

        // Random contents; write while busy and stray starts must be ignored.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = int'($urandom_range(0, 255));
                mb[r][c] = int'($urandom_range(0, 255));
            end
        write_model_rows();
        start_pass();
        run_pass("noise", 1'b0, 1'b1);
        start_pass();
        run_pass("reuse", 1'b0, 1'b0);

        // Back-to-back pass started in the DONE cycle.
        start_pass();
        run_pass("b2b1", 1'b1, 1'b0);
        run_pass("b2b2", 1'b0, 1'b0);

        // Reset mid-pass at t5.
        start_pass();
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", 64'(busy_o), 64'(0));
        chk("midrst west", 64'(west_o), 64'(0));
        chk("midrst done", 64'(done_o), 64'(0));
        chk("midrst load", 64'(load_o), 64'(0));
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        done_seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) done_seen = 1'b1;
        end
        chk("midrst no done", 64'(done_seen), 64'(0));
        start_pass();
        run_pass("cleared", 1'b0, 1'b0);

        // Write of B[3] in the same cycle as start.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = int'($urandom_range(0, 255));
                mb[r][c] = int'($urandom_range(0, 255));
            end
        write_model_rows();
        wr_en_i   = 1'b1;
        wr_sel_i  = 1'b1;
        wr_row_i  = RW'(3);
        wr_data_i = {NB'(8), NB'(7), NB'(6), NB'(5)};
        for (int j = 0; j < N; j++) mb[3][j] = 5 + j;
        start_i = 1'b1;
        @(posedge clk); #1;
        wr_en_i = 1'b0;
        start_i = 1'b0;
        run_pass("wrstart", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream stage of the systolic matrix-multiply array (`top_lvl`). It holds operand matrices A and B, written one row per cycle. On `start_i` it drives the array's `north_i` bus with the B rows during a LOAD phase. It then drives the `west_i` bus with A in diagonally skewed wavefront order during a STREAM phase, and signals `done_o` after a fixed drain window in which the array finishes computing `C_o`.

## Interface
- `N`, default 4: array dimension; matrices are N×N.
- `NUM_BITS`, default 8: element width, matching the array's `NUM_BITS`.
- `DRAIN_CYCLES`, default 8: number of all-zero cycles after STREAM before `done_o`; must be ≥ 1.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_en_i`, in, 1: write one matrix row.
- `wr_sel_i`, in, 1: 0 selects A, 1 selects B.
- `wr_row_i`, in, $clog2(N): row index being written.
- `wr_data_i`, in, [N][NUM_BITS]: row data; `wr_data_i[j]` is column j.
- `start_i`, in, 1: start one multiply pass.
- `busy_o`, out, 1: pass in progress.
- `done_o`, out, 1: one-cycle completion pulse.
- `load_o`, out, 1: high while `north_o` carries B rows.
- `north_o`, out, [N][NUM_BITS]: connects to array `north_i`.
- `west_o`, out, [N][NUM_BITS]: connects to array `west_i`.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE. A single phase counter `t` counts cycles from the start of LOAD.
- **IDLE:** `busy_o=0`. All data outputs are 0.
  - `wr_en_i` commits `wr_data_i` into row `wr_row_i` of A or B at the clock edge.
  - `start_i=1` moves to LOAD.
  - A write in the same cycle as `start_i` commits, and the new data is used by that pass.
- Writes are ignored while `busy_o=1` or in DONE. `start_i` is ignored outside IDLE and DONE.
- **LOAD**, t = 0..N-1:
  - `north_o[j] = B[N-1-t][j]`, so the last row goes first.
  - `load_o=1`. `west_o` is all 0.
- **STREAM**, t = N..3N-2 (2N-1 cycles):
  - `west_o[i] = A[k][i]`, where k = t-N-i, when 0 ≤ k < N. Otherwise `west_o[i]` is 0.
  - Row i of `west_o` therefore lags row i-1 by one cycle.
  - `north_o` is all 0. `load_o=0`.
- **DRAIN**, t = 3N-1 .. 3N-2+DRAIN_CYCLES: all data outputs are 0.
- **DONE:** lasts one cycle. `done_o=1`, `busy_o=0`, outputs are 0.
  - The next state is IDLE.
  - If `start_i=1` in this cycle, the next state is LOAD (back-to-back pass).
- `busy_o=1` in LOAD, STREAM and DRAIN.
- Matrix buffers are not modified by a pass; repeated starts reuse them.
- Element values pass through unchanged. There is no arithmetic and no width change.

## Timing
- All outputs are registered.
- Start edge: `start_i` is sampled high at edge E0.
  - Cycle t=0 is the cycle after E0. In that cycle `north_o` shows `B[N-1]` and `busy_o=1`.
- Total `busy_o` duration is 3N-1+DRAIN_CYCLES cycles.
- `done_o` is high in cycle t = 3N-1+DRAIN_CYCLES.
- Defaults (N=4, DRAIN_CYCLES=8):
  - LOAD is t0-3.
  - STREAM is t4-10. `west_o[0]` first carries `A[0][0]` at t4; `west_o[3]` last carries `A[3][3]` at t10.
  - DRAIN is t11-18.
  - `done_o` is high at t19.
- Reset values: state IDLE, `t=0`, `busy_o=0`, `done_o=0`, `load_o=0`, and `north_o`/`west_o` all 0.
  - Both matrix buffers clear to 0.
- Reset mid-pass: from the next cycle the state is IDLE, outputs are 0, and no `done_o` pulse is issued. `rst` overrides `start_i` and `wr_en_i`.

## Test plan
- **Identity:** write A=I and B=I, pulse start.
  - `north_o[3]=1` at t0, `north_o[2]=1` at t1, `north_o[1]=1` at t2, `north_o[0]=1` at t3.
  - `west_o[0]=1` at t4, `west_o[1]=1` at t6, `west_o[2]=1` at t8, `west_o[3]=1` at t10; zeros elsewhere.
  - `done_o` at t19.
- **Ordering:** write `A[r][c] = 4r+c+1` and `B[r][c] = 16+4r+c`.
  - `north_o` at t0 is {28,29,30,31}.
  - `west_o[2]` carries 3, 7, 11, 15 at t6-t9.
  - Connected to `top_lvl`, `C_o` equals A×B after `done_o`.
- **Write while busy:** during STREAM, write `A[0] = {99,99,99,99}`.
  - The current pass is unchanged.
  - A second pass also shows the original `A[0]`, because the write was ignored.
- **Reset mid-pass:** assert `rst` at t5.
  - At t6, `busy_o=0`, `west_o` is 0, buffers read back 0, and no `done_o` pulse follows.
- **Back-to-back:** assert `start_i` during the DONE cycle.
  - The next cycle shows `busy_o=1` and `north_o = B[3]`.
  - `start_i` pulses during LOAD or DRAIN have no effect.
- **Write+start same cycle:** in IDLE, write `B[3] = {5,6,7,8}` with `start_i=1`.
  - `north_o` at t0 is {5,6,7,8}.
